// File: rtl/flow_zigzag_if.sv
// flow_zigzag_if: coefficient stream bundle, raster beats in and zigzag beats out.
// The slave side is the reorder block; the master side is its environment.
interface flow_zigzag_if #(
    parameter int N = 2
) ();
    logic                 in_valid;
    logic [N-1:0][15:0]   in_data;
    logic                 in_sob;
    logic                 in_eob;
    logic                 in_sof;
    logic                 out_valid;
    logic [N-1:0][15:0]   out_data;
    logic                 out_sob;
    logic                 out_eob;
    logic                 out_sof;
    logic                 out_err;

    modport slave (
        input  in_valid, in_data, in_sob, in_eob, in_sof,
        output out_valid, out_data, out_sob, out_eob, out_sof, out_err
    );

    modport master (
        output in_valid, in_data, in_sob, in_eob, in_sof,
        input  out_valid, out_data, out_sob, out_eob, out_sof, out_err
    );
endinterface

// File: rtl/flow_zigzag.sv
// flow_zigzag: raster-to-zigzag reorder of 8x8 coefficient blocks using
// ping-pong register banks, a framing checker and a two-state read FSM.
module flow_zigzag #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    flow_zigzag_if.slave io
);
    localparam int B  = 64 / N;
    localparam int CW = (B > 1) ? $clog2(B) : 1;
    localparam logic [CW-1:0] LAST = CW'(B - 1);

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {IDLE, RUN} state_e;

    logic [15:0]        bank_q [2][64];
    logic [15:0]        bank_d [2][64];
    logic [CW-1:0]      wcnt_q, wcnt_d, wc;
    logic               wbank_q, wbank_d;
    logic               wsof_q, wsof_d;
    logic               pend_q, pend_d;
    logic               pend_bank_q, pend_bank_d;
    logic               pend_sof_q, pend_sof_d;
    logic               err_q, err_d;
    state_e             state_q, state_d;
    logic [CW-1:0]      rcnt_q, rcnt_d;
    logic               rbank_q, rbank_d;
    logic               rsof_q, rsof_d;
    logic               ov_q, ov_d;
    logic               osob_q, osob_d;
    logic               oeob_q, oeob_d;
    logic               osof_q, osof_d;
    logic [N-1:0][15:0] odata_q, odata_d;
    logic               acc, post, take, ovf, blk_sof;

    // Write side: framing checks and bank fill
    always_comb begin
        acc     = io.in_valid & en;
        wc      = io.in_sob ? '0 : wcnt_q;
        post    = acc && (wc == LAST);
        blk_sof = (wc == '0) ? io.in_sof : wsof_q;
        wcnt_d  = wcnt_q;
        wbank_d = wbank_q;
        wsof_d  = wsof_q;
        bank_d  = bank_q;
        if (acc) begin
            if (wc == '0) wsof_d = io.in_sof;
            for (int i = 0; i < N; i++) begin
                bank_d[wbank_q][6'(N * int'(wc) + i)] = io.in_data[i];
            end
            wcnt_d = post ? '0 : wc + 1'b1;
            if (post) wbank_d = ~wbank_q;
        end
    end

    // Read side: FSM, pending hand-off and registered output beat
    always_comb begin
        take    = 1'b0;
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rbank_d = rbank_q;
        rsof_d  = rsof_q;
        ov_d    = ov_q;
        osob_d  = osob_q;
        oeob_d  = oeob_q;
        osof_d  = osof_q;
        odata_d = odata_q;
        if (en) begin
            ov_d   = 1'b0;
            osob_d = 1'b0;
            oeob_d = 1'b0;
            osof_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pend_q) begin
                        take    = 1'b1;
                        state_d = RUN;
                        rcnt_d  = '0;
                    end
                end
                RUN: begin
                    ov_d   = 1'b1;
                    osob_d = (rcnt_q == '0);
                    oeob_d = (rcnt_q == LAST);
                    osof_d = (rcnt_q == '0) && rsof_q;
                    for (int i = 0; i < N; i++) begin
                        odata_d[i] =
                            bank_q[rbank_q][ZZ[6'(N * int'(rcnt_q) + i)]];
                    end
                    rcnt_d = rcnt_q + 1'b1;
                    if (rcnt_q == LAST) begin
                        rcnt_d = '0;
                        if (pend_q) take = 1'b1;
                        else state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (take) begin
                rbank_d = pend_bank_q;
                rsof_d  = pend_sof_q;
            end
        end
    end

    always_comb begin
        ovf         = post & pend_q & ~take;
        pend_d      = pend_q & ~take;
        pend_bank_d = pend_bank_q;
        pend_sof_d  = pend_sof_q;
        if (post) begin
            pend_d      = 1'b1;
            pend_bank_d = wbank_q;
            pend_sof_d  = blk_sof;
        end
        err_d = err_q | ovf;
        if (acc && io.in_sob && wcnt_q != '0) err_d = 1'b1;
        if (acc && (io.in_eob != (wc == LAST))) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q      <= '0;
            wbank_q     <= 1'b0;
            wsof_q      <= 1'b0;
            pend_q      <= 1'b0;
            pend_bank_q <= 1'b0;
            pend_sof_q  <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= IDLE;
            rcnt_q      <= '0;
            rbank_q     <= 1'b0;
            rsof_q      <= 1'b0;
            ov_q        <= 1'b0;
            osob_q      <= 1'b0;
            oeob_q      <= 1'b0;
            osof_q      <= 1'b0;
            odata_q     <= '0;
        end else begin
            wcnt_q      <= wcnt_d;
            wbank_q     <= wbank_d;
            wsof_q      <= wsof_d;
            pend_q      <= pend_d;
            pend_bank_q <= pend_bank_d;
            pend_sof_q  <= pend_sof_d;
            err_q       <= err_d;
            state_q     <= state_d;
            rcnt_q      <= rcnt_d;
            rbank_q     <= rbank_d;
            rsof_q      <= rsof_d;
            ov_q        <= ov_d;
            osob_q      <= osob_d;
            oeob_q      <= oeob_d;
            osof_q      <= osof_d;
            odata_q     <= odata_d;
        end
    end

    // A stall freezes the registered beat; en gates its visibility
    assign io.out_valid = ov_q & en;
    assign io.out_sob   = osob_q & en;
    assign io.out_eob   = oeob_q & en;
    assign io.out_sof   = osof_q & en;
    assign io.out_data  = odata_q;
    assign io.out_err   = err_q;

    ovf_a: assert property (@(posedge clk) disable iff (!rst_n) !ovf);
endmodule

// File: tb/tb_flow_zigzag.sv
// tb_flow_zigzag: directed stimulus with a block-level reference model
// and a per-cycle output compare for the zigzag reorder block.
module tb_flow_zigzag;
    localparam int N = 2;
    localparam int B = 64 / N;

    typedef struct {
        logic [N-1:0][15:0] d;
        logic               sob;
        logic               eob;
        logic               sof;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    flow_zigzag_if #(.N(N)) io ();

    flow_zigzag #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .io    (io)
    );

    always #5 clk = ~clk;

    int    nchk = 0;
    int    nerr = 0;
    int    cyc = 0;
    bit    togg = 1'b0;
    int    zz [64];
    beat_t q [$];
    beat_t log_q [$];
    logic [15:0] ras [64];
    int    pos = 0;
    bit    sofb = 1'b0;
    bit    exp_err = 1'b0;
    int    run_first = -1;
    int    run_last = -1;
    int    run_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Zigzag order derived by walking the anti-diagonals of the 8x8 block
    function automatic void build_zz();
        int p = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    zz[p] = r * 8 + (s - r);
                    p++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    zz[p] = r * 8 + (s - r);
                    p++;
                end
            end
        end
    endfunction

    // Reference model: assemble blocks, emit their zigzag beats on completion
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            pos = 0;
            exp_err = 1'b0;
        end else if (io.in_valid && en) begin
            if (io.in_sob) begin
                if (pos != 0) exp_err = 1'b1;
                pos = 0;
            end
            if (io.in_eob != (pos == B - 1)) exp_err = 1'b1;
            if (pos == 0) sofb = io.in_sof;
            for (int i = 0; i < N; i++) ras[N * pos + i] = io.in_data[i];
            pos++;
            if (pos == B) begin
                pos = 0;
                for (int j = 0; j < B; j++) begin
                    beat_t b;
                    for (int i = 0; i < N; i++) b.d[i] = ras[zz[N * j + i]];
                    b.sob = (j == 0);
                    b.eob = (j == B - 1);
                    b.sof = (j == 0) && sofb;
                    q.push_back(b);
                end
            end
        end
    end

    beat_t e;
    beat_t a;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("err_flag", io.out_err, exp_err);
            if (!en) chk("stall_valid", io.out_valid, 0);
            if (!io.out_valid) begin
                chk("idle_marks", {io.out_sob, io.out_eob, io.out_sof}, 0);
            end else if (q.size() == 0) begin
                chk("spurious_beat", io.out_valid, 0);
            end else begin
                e = q.pop_front();
                a.d = io.out_data;
                a.sob = io.out_sob;
                a.eob = io.out_eob;
                a.sof = io.out_sof;
                log_q.push_back(a);
                chk("beat_data", io.out_data, e.d);
                chk("beat_marks", {a.sob, a.eob, a.sof}, {e.sob, e.eob, e.sof});
                if (run_first < 0) run_first = cyc;
                run_last = cyc;
                run_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        en = togg ? (cyc % 3 != 0) : 1'b1;
    endtask

    task automatic beat(input logic [15:0] base, input int k,
                        input bit sob, input bit eob, input bit sof);
        bit acc;
        int g = 0;
        io.in_valid = 1'b1;
        for (int i = 0; i < N; i++) io.in_data[i] = base + 16'(N * k + i);
        io.in_sob = sob;
        io.in_eob = eob;
        io.in_sof = sof;
        do begin
            acc = en;
            step();
            g++;
        end while (!acc && g < 10);
        io.in_valid = 1'b0;
        io.in_sob = 1'b0;
        io.in_eob = 1'b0;
        io.in_sof = 1'b0;
    endtask

    task automatic send_block(input logic [15:0] base, input bit sof,
                              input int eob_extra);
        for (int k = 0; k < B; k++) begin
            beat(base, k, k == 0, (k == B - 1) || (k == eob_extra),
                 (k == 0) && sof);
        end
    endtask

    task automatic check_latency(input string nm);
        chk({nm, "_e0"}, io.out_valid, 0);
        step();
        chk({nm, "_e1"}, io.out_valid, 0);
        step();
        chk({nm, "_e2"}, {io.out_valid, io.out_sob}, 2'b11);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || io.out_valid) && t < 400) begin
            step();
            t++;
        end
        chk("drain_left", q.size(), 0);
        repeat (3) step();
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ctl"}, {io.out_valid, io.out_sob, io.out_eob,
                           io.out_sof, io.out_err}, 0);
        chk({nm, "_data"}, io.out_data, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        build_zz();
        io.in_valid = 1'b0;
        io.in_data = '0;
        io.in_sob = 1'b0;
        io.in_eob = 1'b0;
        io.in_sof = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) step();

        chk("zz_pin3", zz[3], 16);
        chk("zz_pin5", zz[5], 2);
        chk("zz_pin42", zz[42], 15);
        chk("zz_pin63", zz[63], 63);

        // Single block, value = raster index
        log_q.delete();
        send_block(16'd0, 1'b1, -1);
        check_latency("lat1");
        drain();
        chk("blk1_count", log_q.size(), 32);
        if (log_q.size() == 32) begin
            chk("blk1_b0", log_q[0].d, 32'h0001_0000);
            chk("blk1_b0m", {log_q[0].sob, log_q[0].eob, log_q[0].sof}, 3'b101);
            chk("blk1_b1", log_q[1].d, 32'h0010_0008);
            chk("blk1_b2", log_q[2].d, 32'h0002_0009);
            chk("blk1_b31", log_q[31].d, 32'h003f_003e);
            chk("blk1_b31m", {log_q[31].sob, log_q[31].eob, log_q[31].sof},
                3'b010);
        end
        chk("blk1_err", io.out_err, 0);

        // Three blocks back to back, one negative-valued
        run_first = -1;
        run_cnt = 0;
        send_block(16'd1000, 1'b1, -1);
        send_block(16'd2000, 1'b0, -1);
        send_block(16'hf000, 1'b0, -1);
        drain();
        chk("b2b_count", run_cnt, 96);
        chk("b2b_span", run_last - run_first + 1, 96);

        // Periodic stall on en
        togg = 1'b1;
        send_block(16'd2500, 1'b1, -1);
        send_block(16'h8000, 1'b0, -1);
        drain();
        togg = 1'b0;
        en = 1'b1;

        // Early end-of-block marker
        send_block(16'd3000, 1'b1, 5);
        drain();
        chk("eob_err", io.out_err, 1);

        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset2");
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Restart mid-block via start marker at beat 10
        for (int k = 0; k < 10; k++) beat(16'd4000, k, k == 0, 1'b0, 1'b0);
        send_block(16'd5000, 1'b1, -1);
        check_latency("lat_sob");
        drain();
        chk("sob_err", io.out_err, 1);

        // Reset while beat 15 is on the output
        send_block(16'd6000, 1'b1, -1);
        repeat (17) step();
        chk("pre_rst_beat15", {io.out_valid, io.out_data},
            {1'b1, 16'd6028, 16'd6021});
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid");
        repeat (2) step();
        rst_n = 1'b1;
        repeat (10) step();
        send_block(16'd7000, 1'b1, -1);
        check_latency("lat_post_rst");
        drain();
        chk("final_queue", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
